// File: rtl/mem_tg_pkg.sv
// Shared types and helpers for the RAM traffic generator: FSM state encoding,
// error counter sizing and the deterministic data pattern.
package mem_tg_pkg;

   typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, DRAIN, DONE} state_t;

   localparam int unsigned ERR_CNT_W = 16;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Pattern arithmetic runs wide; callers truncate to their bus width, which gives the wrap.
   localparam int unsigned PAT_W = 64;

   function automatic logic [PAT_W-1:0] pat_data(input logic [PAT_W-1:0] seed,
                                                 input logic [PAT_W-1:0] idx);
      return seed + idx;
   endfunction

endpackage

// File: rtl/mem_tg_if.sv
// Single-port RAM bus (read_write/address/data/cs/oe) as seen by the traffic generator.
// Bus rule: cs qualifies every cycle; read_write=1 writes wr_data, read_write=0 with oe=1 reads, and
// rd_data carries the addressed word exactly one cycle after the read cycle (no back-pressure).
interface mem_tg_if #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 30
) ();
   logic                     read_write;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     cs;
   logic                     oe;
   logic [DATA_WIDTH-1:0]    rd_data;

   modport master (output read_write, address, wr_data, cs, oe, input rd_data);
   modport slave  (input read_write, address, wr_data, cs, oe, output rd_data);
endinterface

// File: rtl/mem_tg_pattern.sv
// Combinational address/data generator for word index idx of the test window.
module mem_tg_pattern
   import mem_tg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 30,
   parameter int unsigned IDX_W         = 4,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic [DATA_WIDTH-1:0]    seed,
   input  logic [IDX_W-1:0]         idx,
   output logic [ADDRESS_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0]    data
);
   assign addr = BASE_ADDR + ADDRESS_WIDTH'(idx);
   assign data = DATA_WIDTH'(pat_data(PAT_W'(seed), PAT_W'(idx)));
endmodule

// File: rtl/mem_traffic_gen.sv
// RAM traffic generator: writes NUM_WORDS pattern words, reads them back and counts mismatches.
// Optional MEM_TRAFFIC_GEN_ERR_INJECT_EN adds inject_err, which corrupts bit 0 of word 0 on write.
module mem_traffic_gen
   import mem_tg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 30,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned NUM_WORDS     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    seed,
`ifdef MEM_TRAFFIC_GEN_ERR_INJECT_EN
   input  logic                     inject_err,
`endif
   mem_tg_if.master                 bus,
   output logic                     busy,
   output logic                     done,
   output logic [ERR_CNT_W-1:0]     error_count,
   output logic [ADDRESS_WIDTH-1:0] first_err_addr,
   output state_t                   dbg_state
);
   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0]    seed_q, seed_d;
   logic                     rd_vld_q, rd_vld_d;
   logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
   logic [ERR_CNT_W-1:0]     err_cnt_q, err_cnt_d;
   logic [ADDRESS_WIDTH-1:0] first_err_q, first_err_d;

   logic                     cs_q, cs_d;
   logic                     oe_q, oe_d;
   logic                     rw_q, rw_d;
   logic [ADDRESS_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic                     accept;
   logic                     corrupt;
   logic                     mismatch;
   logic [ADDRESS_WIDTH-1:0] wr_addr, exp_addr;
   logic [DATA_WIDTH-1:0]    wr_pat, exp_data;

   assign accept = (state_q == IDLE) && start;

`ifdef MEM_TRAFFIC_GEN_ERR_INJECT_EN
   logic inject_q, inject_d;
   assign inject_d = accept ? inject_err : inject_q;
   assign corrupt  = inject_d && (idx_d == '0);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) inject_q <= 1'b0;
      else     inject_q <= inject_d;
   end
`else
   assign corrupt = 1'b0;
`endif

   // Write stream follows the next index so the bus flops line up with the state register.
   mem_tg_pattern #(
      .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR)
   ) u_wr_pat (
      .seed(seed_d), .idx(idx_d), .addr(wr_addr), .data(wr_pat)
   );

   // Expected stream trails by one cycle, matching the RAM read latency.
   mem_tg_pattern #(
      .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH), .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR)
   ) u_exp_pat (
      .seed(seed_q), .idx(rd_idx_q), .addr(exp_addr), .data(exp_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = WRITE;
            idx_d   = '0;
         end
         WRITE: begin
            if (idx_q == LAST_IDX) begin
               state_d = TURN;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         TURN: begin
            state_d = READ;
            idx_d   = '0;
         end
         READ: begin
            if (idx_q == LAST_IDX) state_d = DRAIN;
            else                   idx_d   = idx_q + IDX_W'(1);
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: decoded from the next state so every bus output is a flop.
   always_comb begin
      cs_d      = 1'b0;
      oe_d      = 1'b0;
      rw_d      = 1'b0;
      address_d = '0;
      wr_data_d = '0;
      done_d    = (state_d == DONE);
      busy_d    = (state_d != IDLE);
      case (state_d)
         WRITE: begin
            cs_d      = 1'b1;
            rw_d      = 1'b1;
            address_d = wr_addr;
            wr_data_d = {wr_pat[DATA_WIDTH-1:1], wr_pat[0] ^ corrupt};
         end
         READ: begin
            cs_d      = 1'b1;
            oe_d      = 1'b1;
            address_d = wr_addr;
         end
         default: ;
      endcase
   end

   // Read-back checking
   assign mismatch = rd_vld_q && (bus.rd_data != exp_data);

   always_comb begin
      seed_d      = accept ? seed : seed_q;
      rd_vld_d    = (state_q == READ);
      rd_idx_d    = idx_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      if (accept) begin
         err_cnt_d   = '0;
         first_err_d = '0;
      end else if (mismatch) begin
         if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         if (err_cnt_q == '0)          first_err_d = exp_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_q      <= '0;
         rd_vld_q    <= 1'b0;
         rd_idx_q    <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         cs_q        <= 1'b0;
         oe_q        <= 1'b0;
         rw_q        <= 1'b0;
         address_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         seed_q      <= seed_d;
         rd_vld_q    <= rd_vld_d;
         rd_idx_q    <= rd_idx_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         cs_q        <= cs_d;
         oe_q        <= oe_d;
         rw_q        <= rw_d;
         address_q   <= address_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.cs         = cs_q;
   assign bus.oe         = oe_q;
   assign bus.read_write = rw_q;
   assign bus.address    = address_q;
   assign bus.wr_data    = wr_data_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error_count    = err_cnt_q;
   assign first_err_addr = first_err_q;
   assign dbg_state      = state_q;

endmodule
